pixel_write_arbiter: RTL and testbench

Merges the pixel streams of the sprite drawers (bullet, player ship, alien rows, shields) into the single pixel-write port of the VGA adapter. Each drawer presents one pixel at a time with a request. The arbiter grants one source per cycle, round-robin, and registers the winning pixel onto the adapter inputs. It also runs a full-screen clear sweep on request, at higher priority than all sources.

---
 rtl/pixel_write_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of sprite pixel streams onto the single VGA adapter write port, with a
// higher-priority full-screen clear sweep. Optional macro BOUNDS_CHECK_EN drops off-screen pixels.
module pixel_write_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         SCREEN_W  = 320,
    parameter int         SCREEN_H  = 240,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_SRC-1:0]   src_req_i,
    input  logic [9*N_SRC-1:0] src_x_i,
    input  logic [8*N_SRC-1:0] src_y_i,
    input  logic [3*N_SRC-1:0] src_colour_i,
    output logic [N_SRC-1:0]   src_gnt_o,
    input  logic               clear_req_i,
    output logic               clear_busy_o,
    output logic               clear_done_o,
    output logic [8:0]         x_o,
    output logic [7:0]         y_o,
    output logic [2:0]         colour_o,
    output logic               plot_o
`ifdef BOUNDS_CHECK_EN
    ,
    output logic [7:0]         drop_count_o
`endif
);

    localparam int         PW     = $clog2(N_SRC);
    localparam logic [8:0] LAST_X = 9'(SCREEN_W - 1);
    localparam logic [7:0] LAST_Y = 8'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rrPtr_q, rrPtr_d;
    logic [8:0]       cx_q, cx_d;
    logic [7:0]       cy_q, cy_d;
    logic [8:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             plot_q, plot_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BOUNDS_CHECK_EN
    logic [7:0]       dropCount_q, dropCount_d;
    logic             offScreen;
`endif

    logic [N_SRC-1:0] eligible;
    logic             found;
    logic [PW-1:0]    winIdx;
    logic [PW-1:0]    cand;
    logic [8:0]       srcX [N_SRC];
    logic [7:0]       srcY [N_SRC];
    logic [2:0]       srcC [N_SRC];

    // Pointer arithmetic wraps by compare so non-power-of-two source counts stay in range.
    function automatic logic [PW-1:0] addWrap(input logic [PW-1:0] base, input logic [PW-1:0] offs);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= (PW+1)'(N_SRC)) sum = sum - (PW+1)'(N_SRC);
        return sum[PW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            srcX[i] = src_x_i[9*i +: 9];
            srcY[i] = src_y_i[8*i +: 8];
            srcC[i] = src_colour_i[3*i +: 3];
        end
    end

    // The source granted last cycle still shows its old request, so it sits out one cycle.
    always_comb begin
        eligible = src_req_i & ~gnt_q;
        found    = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = addWrap(rrPtr_q, PW'(k));
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winIdx = cand;
            end
        end
    end

`ifdef BOUNDS_CHECK_EN
    assign offScreen = ({1'b0, srcX[winIdx]} >= 10'(SCREEN_W)) || ({1'b0, srcY[winIdx]} >= 9'(SCREEN_H));
`endif

    always_comb begin
        state_d  = state_q;
        rrPtr_d  = rrPtr_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        gnt_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef BOUNDS_CHECK_EN
        dropCount_d = dropCount_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    state_d  = CLEAR;
                    cx_d     = '0;
                    cy_d     = '0;
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = BG_COLOUR;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                end else if (found) begin
                    x_d           = srcX[winIdx];
                    y_d           = srcY[winIdx];
                    colour_d      = srcC[winIdx];
                    gnt_d[winIdx] = 1'b1;
                    rrPtr_d       = addWrap(winIdx, PW'(1));
`ifdef BOUNDS_CHECK_EN
                    plot_d = !offScreen;
                    if (offScreen && dropCount_q != 8'hFF) dropCount_d = dropCount_q + 8'd1;
`else
                    plot_d = 1'b1;
`endif
                end
            end
            CLEAR: begin
                // cx/cy track the pixel currently on the outputs; step to the next one.
                if (cx_q == LAST_X) begin
                    cx_d = '0;
                    cy_d = cy_q + 8'd1;
                end else begin
                    cx_d = cx_q + 9'd1;
                end
                x_d      = cx_d;
                y_d      = cy_d;
                colour_d = BG_COLOUR;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (cx_d == LAST_X && cy_d == LAST_Y) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BOUNDS_CHECK_EN
            dropCount_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rrPtr_q  <= rrPtr_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BOUNDS_CHECK_EN
            dropCount_q <= dropCount_d;
`endif
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign colour_o     = colour_q;
    assign plot_o       = plot_q;
    assign src_gnt_o    = gnt_q;
    assign clear_busy_o = busy_q;
    assign clear_done_o = done_q;
`ifdef BOUNDS_CHECK_EN
    assign drop_count_o = dropCount_q;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed and random source traffic compared
// against a behavioural model of arbitration and the clear sweep. Honours BOUNDS_CHECK_EN.
module tb_pixel_write_arbiter;

    localparam int         N_SRC     = 4;
    localparam int         SCREEN_W  = 320;
    localparam int         SCREEN_H  = 240;
    localparam logic [2:0] BG_COLOUR = 3'b000;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [N_SRC-1:0]   srcReq;
    logic [9*N_SRC-1:0] srcXBus;
    logic [8*N_SRC-1:0] srcYBus;
    logic [3*N_SRC-1:0] srcCBus;
    logic [N_SRC-1:0]   srcGnt;
    logic               clearReq = 1'b0;
    logic               clearBusy, clearDone;
    logic [8:0]         xOut;
    logic [7:0]         yOut;
    logic [2:0]         colourOut;
    logic               plotOut;
`ifdef BOUNDS_CHECK_EN
    logic [7:0]         dropCount;
`endif

    pixel_write_arbiter #(
        .N_SRC(N_SRC), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BG_COLOUR(BG_COLOUR)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .src_req_i(srcReq), .src_x_i(srcXBus), .src_y_i(srcYBus), .src_colour_i(srcCBus),
        .src_gnt_o(srcGnt), .clear_req_i(clearReq),
        .clear_busy_o(clearBusy), .clear_done_o(clearDone),
        .x_o(xOut), .y_o(yOut), .colour_o(colourOut), .plot_o(plotOut)
`ifdef BOUNDS_CHECK_EN
        , .drop_count_o(dropCount)
`endif
    );

    // Source-side state, driven by the bench and packed onto the DUT buses.
    logic       reqArr [N_SRC];
    logic [8:0] pxArr  [N_SRC];
    logic [7:0] pyArr  [N_SRC];
    logic [2:0] pcArr  [N_SRC];
    bit         randomMode = 1'b0;

    always_comb begin
        srcReq  = '0;
        srcXBus = '0;
        srcYBus = '0;
        srcCBus = '0;
        for (int i = 0; i < N_SRC; i++) begin
            srcReq[i]         = reqArr[i];
            srcXBus[9*i +: 9] = pxArr[i];
            srcYBus[8*i +: 8] = pyArr[i];
            srcCBus[3*i +: 3] = pcArr[i];
        end
    end

    // Reference model: mode 0 idle, 1 sweeping, 2 done; sweep position is a linear pixel index.
    int               mMode, mIdx, mRr, mLast, eDrop;
    logic [8:0]       eX;
    logic [7:0]       eY;
    logic [2:0]       eCol;
    logic             ePlot, eBusy, eDone;
    logic [N_SRC-1:0] eGnt;

    int assertCount = 0;
    int failCount   = 0;

    task automatic modelReset();
        mMode = 0; mIdx = 0; mRr = 0; mLast = -1; eDrop = 0;
        eX = '0; eY = '0; eCol = '0; ePlot = 1'b0; eBusy = 1'b0; eDone = 1'b0; eGnt = '0;
    endtask

    task automatic modelEdge();
        int  w;
        bit  hit;
        bit  onScreen;
        eGnt  = '0;
        ePlot = 1'b0;
        eBusy = 1'b0;
        eDone = 1'b0;
        if (mMode == 0) begin
            if (clearReq) begin
                mMode = 1; mIdx = 0; mLast = -1;
                eX = '0; eY = '0; eCol = BG_COLOUR; ePlot = 1'b1; eBusy = 1'b1;
            end else begin
                hit = 1'b0;
                w   = 0;
                for (int k = 0; k < N_SRC; k++) begin
                    int s;
                    s = (mRr + k) % N_SRC;
                    if (!hit && reqArr[s] && s != mLast) begin
                        hit = 1'b1;
                        w   = s;
                    end
                end
                if (hit) begin
                    eX = pxArr[w]; eY = pyArr[w]; eCol = pcArr[w];
                    eGnt[w] = 1'b1;
                    mRr     = (w + 1) % N_SRC;
                    mLast   = w;
                    onScreen = (int'(pxArr[w]) < SCREEN_W) && (int'(pyArr[w]) < SCREEN_H);
`ifdef BOUNDS_CHECK_EN
                    ePlot = onScreen;
                    if (!onScreen && eDrop < 255) eDrop++;
`else
                    ePlot = 1'b1;
`endif
                end else begin
                    mLast = -1;
                end
            end
        end else if (mMode == 1) begin
            mIdx++;
            eX = 9'(mIdx % SCREEN_W);
            eY = 8'(mIdx / SCREEN_W);
            eCol = BG_COLOUR; ePlot = 1'b1; eBusy = 1'b1;
            if (mIdx == SCREEN_W*SCREEN_H - 1) mMode = 2;
        end else begin
            eDone = 1'b1;
            mMode = 0;
            mLast = -1;
        end
    endtask

    task automatic newPixel(input int i);
        pxArr[i] = ($urandom_range(0, 15) == 0) ? 9'(9'h1F0 + $urandom_range(0, 15)) : 9'($urandom_range(0, SCREEN_W-1));
        pyArr[i] = ($urandom_range(0, 15) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, SCREEN_H-1));
        pcArr[i] = 3'($urandom_range(0, 7));
    endtask

    // Sources react to the grant the model predicts, never to what the DUT shows.
    task automatic updateSources();
        for (int i = 0; i < N_SRC; i++) begin
            if (randomMode) begin
                if (eGnt[i]) begin
                    if ($urandom_range(0, 1) == 0) reqArr[i] = 1'b0;
                    else newPixel(i);
                end else if (!reqArr[i] && $urandom_range(0, 3) == 0) begin
                    reqArr[i] = 1'b1;
                    newPixel(i);
                end
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        assertCount++;
        assert ({plotOut, srcGnt, clearBusy, clearDone} === {ePlot, eGnt, eBusy, eDone}) else begin
            failCount++;
            $error("[TB] FAIL %s ctrl observed=%h expected=%h", tag,
                   {plotOut, srcGnt, clearBusy, clearDone}, {ePlot, eGnt, eBusy, eDone});
        end
        if (ePlot) begin
            assertCount++;
            assert ({xOut, yOut, colourOut} === {eX, eY, eCol}) else begin
                failCount++;
                $error("[TB] FAIL %s pixel observed=%h expected=%h", tag, {xOut, yOut, colourOut}, {eX, eY, eCol});
            end
        end
`ifdef BOUNDS_CHECK_EN
        checkValue({tag, " drop"}, 32'(dropCount), 32'(eDrop));
`endif
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
        updateSources();
    endtask

    task automatic checkAllZero(input string tag);
        checkValue(tag, {20'd0, xOut, yOut, colourOut, plotOut, srcGnt, clearBusy, clearDone}, 32'd0);
`ifdef BOUNDS_CHECK_EN
        checkValue({tag, " drop"}, 32'(dropCount), 32'd0);
`endif
    endtask

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    task automatic resetMid(input string tag);
        #2 rstN = 1'b0;
        #1 checkAllZero(tag);
        for (int i = 0; i < N_SRC; i++) reqArr[i] = 1'b0;
        clearReq = 1'b0;
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        int plotCnt, busyCnt, cyc, preRr;
        for (int i = 0; i < N_SRC; i++) begin
            reqArr[i] = 1'b0; pxArr[i] = '0; pyArr[i] = '0; pcArr[i] = '0;
        end
        modelReset();

        #3 checkAllZero("reset state");
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus("idle after reset");

        // Single source holding its pixel is served on alternate cycles.
        reqArr[0] = 1'b1; pxArr[0] = 9'd100; pyArr[0] = 8'd50; pcArr[0] = 3'b001;
        plotCnt = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus("single source");
            if (plotOut) plotCnt++;
        end
        checkValue("single source pulses", 32'(plotCnt), 32'd3);

        // All sources saturating the port.
        for (int i = 0; i < N_SRC; i++) begin
            reqArr[i] = 1'b1; pxArr[i] = 9'(10 + i); pyArr[i] = 8'(20 + i); pcArr[i] = 3'(i + 1);
        end
        plotCnt = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus("all sources");
            if (plotOut) plotCnt++;
        end
        checkValue("all sources saturate", 32'(plotCnt), 32'd8);

        resetMid("reset mid-stream");
        for (int c = 0; c < 3; c++) applyStimulus("idle after mid reset");

        randomMode = 1'b1;
        for (int c = 0; c < 400; c++) applyStimulus("random traffic");
        randomMode = 1'b0;

        // Full clear with every source requesting on the same edge as the clear.
        for (int i = 0; i < N_SRC; i++) begin
            if (!reqArr[i]) begin
                reqArr[i] = 1'b1;
                newPixel(i);
            end
        end
        preRr    = mRr;
        clearReq = 1'b1;
        applyStimulus("clear start");
        clearReq = 1'b0;
        checkValue("clear first pixel", {23'd0, xOut}, 32'd0);
        busyCnt = clearBusy ? 1 : 0;
        cyc     = 0;
        while (!clearDone && cyc < SCREEN_W*SCREEN_H + 10) begin
            applyStimulus("clear sweep");
            if (clearBusy) busyCnt++;
            cyc++;
        end
        checkValue("clear busy cycles", 32'(busyCnt), 32'(SCREEN_W*SCREEN_H));
        checkValue("clear done seen", {31'd0, clearDone}, 32'd1);
        applyStimulus("resume after clear");
        checkValue("resume rr pointer", 32'(srcGnt), 32'(4'(1 << preRr)));
        for (int c = 0; c < 6; c++) applyStimulus("post clear traffic");

        // Reset part way through a sweep, then restart from the origin.
        for (int i = 0; i < N_SRC; i++) reqArr[i] = 1'b0;
        applyStimulus("drain");
        applyStimulus("drain");
        clearReq = 1'b1;
        applyStimulus("second clear start");
        clearReq = 1'b0;
        for (int c = 0; c < 5*SCREEN_W + 10; c++) applyStimulus("second sweep");
        checkValue("sweep at (10,5)", {15'd0, xOut, yOut}, {15'd0, 9'd10, 8'd5});
        resetMid("reset mid-sweep");
        applyStimulus("idle after sweep reset");
        clearReq = 1'b1;
        applyStimulus("restart clear");
        clearReq = 1'b0;
        checkValue("restart origin", {15'd0, xOut, yOut}, 32'd0);
        for (int c = 0; c < 20; c++) applyStimulus("restart sweep");
        resetMid("abort sweep");
        applyStimulus("idle before bounds");

        // Bullet x underflow wrapping to 9'h1FB.
        reqArr[1] = 1'b1; pxArr[1] = 9'h1FB; pyArr[1] = 8'd10; pcArr[1] = 3'd5;
        applyStimulus("off-screen pixel");
        checkValue("off-screen grant", 32'(srcGnt), 32'h2);
`ifdef BOUNDS_CHECK_EN
        checkValue("off-screen dropped", {31'd0, plotOut}, 32'd0);
        checkValue("drop count", 32'(dropCount), 32'd1);
`else
        checkValue("off-screen plotted", {31'd0, plotOut}, 32'd1);
        checkValue("off-screen x", {23'd0, xOut}, 32'h1FB);
`endif
        reqArr[1] = 1'b0;
        applyStimulus("final idle");
        applyStimulus("final idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
